// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback entry type, source enum and default sizing for wb_arbiter
package wb_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;
  typedef enum logic {SRC_ALU, SRC_MEM} wb_src_e;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: power-of-two writeback entry buffer; WB_FWD_EN exposes storage and head for forwarding search
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                pushData,
  input  logic                     pop,
`ifdef WB_FWD_EN
  output wb_entry_t [DEPTH-1:0]    slots,
  output logic [$clog2(DEPTH)-1:0] head,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                peek
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t [DEPTH-1:0] mem;
  logic [AW-1:0] wrPtr, rdPtr;
  assign peek = mem[rdPtr];
`ifdef WB_FWD_EN
  assign slots = mem;
  assign head = rdPtr;
`endif
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= pushData;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(push);
      rdPtr <= rdPtr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: ALU/load writeback arbiter with MEM priority and ALU starvation guard; WB_FWD_EN adds a forwarding search
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
`ifdef WB_FWD_EN
  input  logic [4:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
`endif
  output logic        regWrite,
  output logic [4:0]  writeAddr,
  output logic [31:0] writeData
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [AW:0] aluCount, memCount;
  wb_entry_t aluPeek, memPeek, winner;
  logic [SW-1:0] starve;
  logic aluWin, memWin, doWrite;
`ifdef WB_FWD_EN
  wb_entry_t [DEPTH-1:0] aluSlots, memSlots;
  logic [AW-1:0] aluHead, memHead, idx;
`endif
  assign alu_ready = !reset && aluCount < FULL;
  assign mem_ready = !reset && memCount < FULL;
  wb_fifo #(.DEPTH(DEPTH)) uAluFifo (
    .clk, .reset,
    .push(alu_valid && alu_ready),
    .pushData(wb_entry_t'{rd: alu_rd, data: alu_data}),
    .pop(aluWin),
`ifdef WB_FWD_EN
    .slots(aluSlots), .head(aluHead),
`endif
    .count(aluCount), .peek(aluPeek)
  );
  wb_fifo #(.DEPTH(DEPTH)) uMemFifo (
    .clk, .reset,
    .push(mem_valid && mem_ready),
    .pushData(wb_entry_t'{rd: mem_rd, data: mem_data}),
    .pop(memWin),
`ifdef WB_FWD_EN
    .slots(memSlots), .head(memHead),
`endif
    .count(memCount), .peek(memPeek)
  );
  always_comb begin
    aluWin = aluCount != '0 && (memCount == '0 || starve == LIMIT);
    memWin = memCount != '0 && !aluWin;
    winner = aluWin ? aluPeek : memPeek;
    doWrite = (aluWin || memWin) && winner.rd != 5'd0;
  end
  // MEM only wins against a waiting ALU while starve < LIMIT, so the increment saturates by construction
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      regWrite <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
      starve <= '0;
    end else begin
      regWrite <= doWrite;
      if (doWrite) begin
        writeAddr <= winner.rd;
        writeData <= winner.data;
      end
      starve <= (memWin && aluCount != '0) ? starve + SW'(1) : '0;
    end
`ifdef WB_FWD_EN
  // later matches override earlier ones, so scan oldest to youngest
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    idx = '0;
    if (fwd_addr != 5'd0) begin
      if (regWrite && writeAddr == fwd_addr) begin
        fwd_hit = 1'b1;
        fwd_data = writeData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = memHead + AW'(i);
        if ((AW+1)'(i) < memCount && memSlots[idx].rd == fwd_addr) begin
          fwd_hit = 1'b1;
          fwd_data = memSlots[idx].data;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = aluHead + AW'(i);
        if ((AW+1)'(i) < aluCount && aluSlots[idx].rd == fwd_addr) begin
          fwd_hit = 1'b1;
          fwd_data = aluSlots[idx].data;
        end
      end
    end
  end
`endif
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, 2, entries per source buffer (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, 4, consecutive ALU losses before ALU is forced to win.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 alu_valid / alu_rd / alu_data  input  1 / 5 / 32  ALU writeback request: valid, destination register, value.
REQ-006 alu_ready  output  1  ALU buffer can accept this cycle.
REQ-007 mem_valid / mem_rd / mem_data  input  1 / 5 / 32  load-unit writeback request: valid, destination register, value.
REQ-008 mem_ready  output  1  load buffer can accept this cycle.
REQ-009 regWrite  output  1  register-file write strobe, registered.
REQ-010 writeAddr  output  5  register-file destination, registered.
REQ-011 writeData  output  32  register-file write value, registered.

Function
REQ-012 A request SHALL be accepted on a rising edge where valid && ready; it is pushed into that source's FIFO.
REQ-013 Ready SHALL be 1 when the source FIFO count < DEPTH and reset is low; ready depends only on registered count, so a full FIFO never accepts, even while popping that cycle.
REQ-014 Each cycle at most one entry SHALL be popped; the popped entry drives regWrite=1, writeAddr=rd, writeData=data on the following edge, else regWrite=0 and writeAddr/writeData hold.
REQ-015 Minimum latency SHALL be 1 cycle: a request accepted at edge N on an empty FIFO that wins arbitration appears on regWrite after edge N+1.
REQ-016 Arbitration: if only one FIFO is non-empty it wins; if both are non-empty, MEM wins unless the starve counter equals STARVE_LIMIT, in which case ALU wins.
REQ-017 Starve counter SHALL increment (saturating at STARVE_LIMIT) each cycle ALU FIFO is non-empty and MEM wins; clear when ALU wins or ALU FIFO is empty.
REQ-018 Entries with rd==0 SHALL be consumed through normal arbitration but produce regWrite=0 on their cycle.
REQ-019 Order within one source SHALL be preserved (FIFO); cross-source ordering to the same rd is not guaranteed and is the issuer's responsibility.
REQ-020 Pointers SHALL wrap modulo DEPTH; count width is clog2(DEPTH)+1.

Reset
REQ-021 While reset is high: regWrite=0, writeAddr=0, writeData=0, alu_ready=0, mem_ready=0, FIFOs empty, starve counter 0.
REQ-022 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronously); no pending write survives reset.
REQ-023 First acceptance possible on the first rising edge after reset deasserts.

Configuration
REQ-024 Macro WB_FWD_EN SHALL, when defined, add fwd_addr input 5, fwd_hit output 1, fwd_data output 32: combinationally search both FIFOs and the output register for fwd_addr (nonzero), youngest match wins (output register oldest, then MEM FIFO, then ALU FIFO, newest-first within each).
REQ-025 Without WB_FWD_EN those ports and the search logic SHALL not exist; all other behaviour identical.

Structure
REQ-026 Shared package wb_pkg SHALL hold wb_entry_t (rd 5, data 32), the source enum (SRC_ALU, SRC_MEM) and default DEPTH/STARVE_LIMIT constants.
REQ-027 One sub-module wb_fifo (parameterised DEPTH, wb_entry_t payload, push/pop/count/peek) SHALL be instantiated once per source.

Verification
REQ-028 Single ALU write: alu rd=5 data=32'hBABAFFFB accepted at edge N -> regWrite=1, writeAddr=5, writeData=32'hBABAFFFB after edge N+1, regWrite=0 next cycle.
REQ-029 Simultaneous: ALU rd=3 32'h11111111 and MEM rd=4 32'h22222222 same edge -> MEM write first, ALU write next cycle.
REQ-030 Starvation: MEM streams continuously, ALU holds one entry -> ALU write appears after exactly 4 MEM writes.
REQ-031 Full: ALU pushes 3 back-to-back while MEM saturates -> alu_ready=0 after 2 accepted, third held until a pop; all 3 written in order.
REQ-032 rd=0: MEM rd=0 data=32'hFFFFFFFF -> no regWrite pulse, mem_ready unaffected, following entry written normally.
REQ-033 Reset mid-stream: reset pulsed with 2 entries buffered -> regWrite=0 immediately, readies 0, no buffered entry ever written after release.
